// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DBIT_MAX data bits, optional parity, 1/2 stop bits,
// 3-sample majority voting, error/break detection and a valid/ready output holding register.
module uart_rx_cfg #(
   parameter int DBIT_MAX    = 9,
   parameter int OS          = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   input  logic                s_tick,
   input  logic [3:0]          cfg_dbits,
   input  logic [1:0]          cfg_parity,
   input  logic                cfg_stop,
   output logic [DBIT_MAX-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic                parity_err,
   output logic                frame_err,
   output logic                overrun_err,
   input  logic                err_clr,
   output logic                break_det,
   output logic                busy
);
   localparam int SW = $clog2(OS);
   localparam int NW = $clog2(DBIT_MAX + 1);
   localparam logic [SW-1:0] S_V0   = SW'(OS / 2 - 1);
   localparam logic [SW-1:0] S_V1   = SW'(OS / 2);
   localparam logic [SW-1:0] S_V2   = SW'(OS / 2 + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   // Synchroniser flops come out of reset at the idle level so no false start is seen.
   logic [SYNC_STAGES-1:0] sync_reg;
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk or posedge reset) begin
            if (reset)        sync_reg[gi] <= 1'b1;
            else if (gi == 0) sync_reg[gi] <= rx;
            else              sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
         end
      end
   endgenerate

   logic rxs;
   assign rxs = sync_reg[SYNC_STAGES-1];

   state_t               state_reg;
   logic [SW-1:0]        s_reg;
   logic [NW-1:0]        n_reg, dbits_reg;
   logic [DBIT_MAX-1:0]  data_reg, done_data_reg;
   logic                 vote0_reg, vote1_reg;
   logic                 par_en_reg, par_odd_reg, two_stop_reg, stop_idx_reg;
   logic                 par_bit_reg, par_err_reg, ferr_reg, stop0_zero_reg;
   logic                 done_reg, done_perr_reg, done_ferr_reg, break_reg;

   logic [NW-1:0] dbits_cfg;
   logic          voted, at_v2, brk_now;

   always_comb begin
      dbits_cfg = NW'(cfg_dbits);
      if (cfg_dbits < 4'd5)                dbits_cfg = NW'(5);
      else if (int'(cfg_dbits) > DBIT_MAX) dbits_cfg = NW'(DBIT_MAX);
   end

   assign voted = (vote0_reg & vote1_reg) | (vote0_reg & rxs) | (vote1_reg & rxs);
   assign at_v2 = s_tick && (s_reg == S_V2);
   // Break: all-zero data, zero parity bit (if any) and a zero first stop bit.
   assign brk_now = (data_reg == '0) && (!par_en_reg || !par_bit_reg) &&
                    (stop_idx_reg ? stop0_zero_reg : !voted);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         s_reg          <= '0;
         n_reg          <= '0;
         dbits_reg      <= '0;
         data_reg       <= '0;
         vote0_reg      <= 1'b0;
         vote1_reg      <= 1'b0;
         par_en_reg     <= 1'b0;
         par_odd_reg    <= 1'b0;
         two_stop_reg   <= 1'b0;
         stop_idx_reg   <= 1'b0;
         par_bit_reg    <= 1'b0;
         par_err_reg    <= 1'b0;
         ferr_reg       <= 1'b0;
         stop0_zero_reg <= 1'b0;
         done_reg       <= 1'b0;
         done_data_reg  <= '0;
         done_perr_reg  <= 1'b0;
         done_ferr_reg  <= 1'b0;
         break_reg      <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         break_reg <= 1'b0;
         if (s_tick && s_reg == S_V0) vote0_reg <= rxs;
         if (s_tick && s_reg == S_V1) vote1_reg <= rxs;
         case (state_reg)
            IDLE: if (!rxs) begin
               dbits_reg    <= dbits_cfg;
               par_en_reg   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
               par_odd_reg  <= (cfg_parity == 2'b10);
               two_stop_reg <= cfg_stop;
               s_reg        <= '0;
               state_reg    <= START;
            end
            START: if (s_tick) begin
               if (at_v2 && voted) state_reg <= IDLE;
               else if (s_reg == S_LAST) begin
                  s_reg       <= '0;
                  n_reg       <= '0;
                  data_reg    <= '0;
                  par_bit_reg <= 1'b0;
                  par_err_reg <= 1'b0;
                  state_reg   <= DATA;
               end else s_reg <= s_reg + 1'b1;
            end
            DATA: if (s_tick) begin
               if (at_v2)
                  for (int i = 0; i < DBIT_MAX; i++)
                     if (n_reg == NW'(i)) data_reg[i] <= voted;
               if (s_reg == S_LAST) begin
                  s_reg <= '0;
                  if (n_reg == dbits_reg - NW'(1)) begin
                     stop_idx_reg <= 1'b0;
                     ferr_reg     <= 1'b0;
                     state_reg    <= par_en_reg ? PARITY : STOP;
                  end else n_reg <= n_reg + 1'b1;
               end else s_reg <= s_reg + 1'b1;
            end
            PARITY: if (s_tick) begin
               if (at_v2) begin
                  par_bit_reg <= voted;
                  par_err_reg <= (^data_reg) ^ voted ^ par_odd_reg;
               end
               if (s_reg == S_LAST) begin
                  s_reg        <= '0;
                  stop_idx_reg <= 1'b0;
                  ferr_reg     <= 1'b0;
                  state_reg    <= STOP;
               end else s_reg <= s_reg + 1'b1;
            end
            STOP: if (s_tick) begin
               if (at_v2 && stop_idx_reg == two_stop_reg) begin
                  // Complete mid-bit of the last stop bit to leave resync margin.
                  if (brk_now) break_reg <= 1'b1;
                  else begin
                     done_reg      <= 1'b1;
                     done_data_reg <= data_reg;
                     done_perr_reg <= par_err_reg;
                     done_ferr_reg <= ferr_reg | !voted;
                  end
                  s_reg     <= '0;
                  state_reg <= rxs ? IDLE : WAIT_HIGH;
               end else begin
                  if (at_v2) begin
                     stop0_zero_reg <= !voted;
                     ferr_reg       <= ferr_reg | !voted;
                  end
                  if (s_reg == S_LAST) begin
                     s_reg        <= '0;
                     stop_idx_reg <= 1'b1;
                  end else s_reg <= s_reg + 1'b1;
               end
            end
            WAIT_HIGH: if (rxs) state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout        <= '0;
         dout_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         break_det <= break_reg;
         if (done_reg && (!dout_valid || dout_ready)) begin
            dout       <= done_data_reg;
            parity_err <= done_perr_reg;
            frame_err  <= done_ferr_reg;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (done_reg && dout_valid && !dout_ready) overrun_err <= 1'b1;
         else if (err_clr)                          overrun_err <= 1'b0;
      end
   end

   assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised self-checking bench for uart_rx_cfg; expected words come from a bit-level frame model.
module tb_uart_rx_cfg;
   localparam int OS     = 16;
   localparam int TDIV   = 2;
   localparam int BITCLK = OS * TDIV;

   logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, s_tick = 1'b0;
   logic [3:0] cfg_dbits = 4'd8;
   logic [1:0] cfg_parity = 2'b00;
   logic       cfg_stop = 1'b0;
   logic [8:0] dout;
   logic       dout_valid, dout_ready = 1'b1, parity_err, frame_err, overrun_err;
   logic       err_clr = 1'b0, break_det, busy;

   int checks = 0, errors = 0;
   int valid_cycles = 0, break_cnt = 0;

   typedef struct { logic [8:0] d; logic pe; logic fe; } word_t;
   word_t got_q[$];

   uart_rx_cfg #(.DBIT_MAX(9), .OS(OS), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
      .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
      .err_clr(err_clr), .break_det(break_det), .busy(busy)
   );

   always #5 clk = ~clk;

   bit tick_ph = 1'b0;
   always @(negedge clk) begin
      tick_ph = ~tick_ph;
      s_tick  = tick_ph;
   end

   always @(negedge clk) begin
      if (dout_valid && dout_ready) got_q.push_back('{dout, parity_err, frame_err});
      if (dout_valid) valid_cycles++;
      if (break_det)  break_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BITCLK) @(negedge clk);
   endtask

   // Drives one frame and returns what the line-level rules say must come out of it.
   task automatic send_frame(input logic [8:0] data, input int dbits, input int par,
                             input bit pflip, input bit two_stop, input logic [1:0] stop_zero,
                             output logic [8:0] ew, output logic epe, output logic efe,
                             output logic ebrk);
      int   dbe;
      bit   pen;
      logic pbit;
      dbe  = (dbits < 5) ? 5 : (dbits > 9) ? 9 : dbits;
      pen  = (par == 1) || (par == 2);
      ew   = data & 9'((1 << dbe) - 1);
      pbit = (^ew) ^ (par == 2) ^ pflip;
      epe  = pen && pflip;
      efe  = stop_zero[0] || (two_stop && stop_zero[1]);
      ebrk = (ew == 9'd0) && (!pen || !pbit) && stop_zero[0];
      cfg_dbits  = 4'(dbits);
      cfg_parity = 2'(par);
      cfg_stop   = two_stop;
      drive_bit(1'b0);
      cfg_dbits  = 4'($urandom);
      cfg_parity = 2'($urandom);
      cfg_stop   = 1'($urandom);
      for (int i = 0; i < dbe; i++) drive_bit(ew[i]);
      if (pen) drive_bit(pbit);
      drive_bit(~stop_zero[0]);
      if (two_stop) drive_bit(~stop_zero[1]);
      drive_bit(1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks += 7;
      if (dout !== 9'd0)      begin errors++; $display("FAIL reset_dout: got %h expected 000", dout); end
      if (dout_valid !== 0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
      if (parity_err !== 0)   begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
      if (frame_err !== 0)    begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      if (overrun_err !== 0)  begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun_err); end
      if (break_det !== 0)    begin errors++; $display("FAIL reset_brk: got %b expected 0", break_det); end
      if (busy !== 0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Sends one frame per table row and checks the delivered word or the break pulse.
   task automatic test_frames(input string name, input int cnt, input bit rand_mode);
      logic [8:0] data, ew;
      logic       epe, efe, ebrk;
      logic [1:0] sz;
      int         dbits, par, b0, v0;
      bit         pflip, two;
      for (int k = 0; k < cnt; k++) begin
         data = 9'($urandom); dbits = $urandom_range(0, 15); par = $urandom_range(0, 3);
         pflip = 1'($urandom); two = 1'($urandom);
         sz = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 5) == 0) data = 9'd0;
         if (!rand_mode) begin
            case (k)
               0: begin data = 9'h0A5; dbits = 8; par = 0; pflip = 0; two = 0; sz = 0; end
               1: begin data = 9'h035; dbits = 7; par = 1; pflip = 0; two = 1; sz = 0; end
               2: begin data = 9'h035; dbits = 7; par = 1; pflip = 1; two = 1; sz = 0; end
               3: begin data = 9'h1FF; dbits = 9; par = 0; pflip = 0; two = 0; sz = 0; end
               4: begin data = 9'h013; dbits = 5; par = 0; pflip = 0; two = 0; sz = 0; end
               5: begin data = 9'h1F3; dbits = 2; par = 3; pflip = 0; two = 0; sz = 0; end
               6: begin data = 9'h155; dbits = 15; par = 2; pflip = 0; two = 0; sz = 0; end
               default: begin data = 9'h05A; dbits = 8; par = 0; pflip = 0; two = 1; sz = 2'b10; end
            endcase
         end
         b0 = break_cnt; v0 = valid_cycles;
         send_frame(data, dbits, par, pflip, two, sz, ew, epe, efe, ebrk);
         if (ebrk) begin
            checks += 2;
            if (break_cnt - b0 != 1) begin errors++; $display("FAIL %s_break[%0d]: got %0d pulses expected 1", name, k, break_cnt - b0); end
            if (got_q.size() != 0)   begin errors++; $display("FAIL %s_break_word[%0d]: got %0d words expected 0", name, k, got_q.size()); end
            got_q.delete();
         end else begin
            checks++;
            if (got_q.size() != 1) begin
               errors++; $display("FAIL %s_count[%0d]: got %0d words expected 1", name, k, got_q.size());
               got_q.delete();
            end else begin
               word_t w;
               w = got_q.pop_front();
               checks += 4;
               if (w.d !== ew)   begin errors++; $display("FAIL %s_dout[%0d]: got %h expected %h", name, k, w.d, ew); end
               if (w.pe !== epe) begin errors++; $display("FAIL %s_perr[%0d]: got %b expected %b", name, k, w.pe, epe); end
               if (w.fe !== efe) begin errors++; $display("FAIL %s_ferr[%0d]: got %b expected %b", name, k, w.fe, efe); end
               if (valid_cycles - v0 != 1) begin errors++; $display("FAIL %s_vcycles[%0d]: got %0d expected 1", name, k, valid_cycles - v0); end
            end
         end
         $display("frame %s[%0d] data=%h dbits=%0d par=%0d two=%0d stopz=%b exp=%h brk=%b", name, k, data, dbits, par, two, sz, ew, ebrk);
      end
   endtask

   task automatic test_glitch();
      int v0;
      v0 = valid_cycles;
      rx = 1'b0;
      repeat (5 * TDIV) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
      rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
      checks += 2;
      if (busy !== 1'b0)        begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", busy); end
      if (valid_cycles != v0)   begin errors++; $display("FAIL glitch_valid: got %0d cycles expected 0", valid_cycles - v0); end
      $display("glitch: rx low %0d ticks", 5);
   endtask

   task automatic test_overrun();
      logic [8:0] ew;
      logic       epe, efe, ebrk;
      dout_ready = 1'b0;
      send_frame(9'h011, 8, 0, 1'b0, 1'b0, 2'b00, ew, epe, efe, ebrk);
      send_frame(9'h022, 8, 0, 1'b0, 1'b0, 2'b00, ew, epe, efe, ebrk);
      checks += 3;
      if (dout !== 9'h011)     begin errors++; $display("FAIL ovr_dout: got %h expected 011", dout); end
      if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", dout_valid); end
      if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_err); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
      checks += 2;
      if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b expected 0", overrun_err); end
      if (dout_valid !== 1'b1)  begin errors++; $display("FAIL ovr_hold: got %b expected 1", dout_valid); end
      dout_ready = 1'b1; @(negedge clk); @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume: got %b expected 0", dout_valid); end
      got_q.delete();
      $display("overrun: frames 011,022 with dout_ready=0");
   endtask

   task automatic test_break();
      int b0, v0;
      b0 = break_cnt; v0 = valid_cycles;
      cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 1'b0;
      rx = 1'b0;
      repeat (3 * 10 * BITCLK) @(negedge clk);
      checks += 3;
      if (break_cnt - b0 != 1) begin errors++; $display("FAIL break_pulse: got %0d expected 1", break_cnt - b0); end
      if (valid_cycles != v0)  begin errors++; $display("FAIL break_valid: got %0d expected 0", valid_cycles - v0); end
      if (busy !== 1'b1)       begin errors++; $display("FAIL break_wait: got %b expected 1", busy); end
      rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", busy); end
      $display("break: rx low for 3 frame times");
   endtask

   task automatic test_reset_mid();
      cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 1'b0;
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
      repeat (BITCLK / 2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (dout !== 9'd0)        begin errors++; $display("FAIL rstmid_dout: got %h expected 000", dout); end
      if (dout_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
      if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      if (frame_err !== 1'b0)   begin errors++; $display("FAIL rstmid_ferr: got %b expected 0", frame_err); end
      rx = 1'b1; reset = 1'b0;
      repeat (BITCLK) @(negedge clk);
      $display("reset mid-DATA applied");
      test_frames("after_rst", 1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_frames("directed", 8, 1'b0);
      test_glitch();
      test_overrun();
      test_break();
      test_frames("random", 24, 1'b1);
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
